// File: rtl/rf_ctx.sv
// Parametrised R/T register file with two combinational read ports, shared FunSel
// write path, and a one-register-per-cycle context save/restore of the R bank.
module rf_ctx #(
  parameter int WIDTH = 8,
  parameter int NUM_R = 4,
  parameter int NUM_T = 4,
  localparam int SELW = $clog2(NUM_R + NUM_T)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  o1_sel,
  input  logic [SELW-1:0]  o2_sel,
  input  logic [1:0]       fun_sel,
  input  logic [NUM_R-1:0] r_sel,
  input  logic [NUM_T-1:0] t_sel,
  input  logic [WIDTH-1:0] i,
  input  logic             ctx_req,
  input  logic             ctx_cmd,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic             ctx_busy,
  output logic             ctx_done,
  output logic             ctx_err,
  output logic             shadow_valid
);

  localparam int IDXW = (NUM_R > 1) ? $clog2(NUM_R) : 1;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] r_q  [NUM_R];
  logic [WIDTH-1:0] t_q  [NUM_T];
  logic [WIDTH-1:0] sh_q [NUM_R];

  function automatic logic [WIDTH-1:0] fun_op(input logic [1:0] f,
                                              input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] res;
    case (f)
      2'b00:   res = cur - WIDTH'(1);
      2'b01:   res = cur + WIDTH'(1);
      2'b10:   res = d;
      default: res = '0;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      ctx_busy     <= 1'b0;
      ctx_done     <= 1'b0;
      ctx_err      <= 1'b0;
      shadow_valid <= 1'b0;
      for (int j = 0; j < NUM_R; j++) begin
        r_q[j]  <= '0;
        sh_q[j] <= '0;
      end
      for (int j = 0; j < NUM_T; j++) t_q[j] <= '0;
    end else begin
      ctx_done <= 1'b0;
      ctx_err  <= 1'b0;

      for (int j = 0; j < NUM_T; j++)
        if (t_sel[j]) t_q[j] <= fun_op(fun_sel, t_q[j], i);

      // R bank belongs to the context engine while a sequence runs
      if (state == IDLE)
        for (int j = 0; j < NUM_R; j++)
          if (r_sel[j]) r_q[j] <= fun_op(fun_sel, r_q[j], i);

      case (state)
        IDLE: begin
          if (ctx_req) begin
            if (!ctx_cmd) begin
              state    <= SAVE;
              idx      <= '0;
              ctx_busy <= 1'b1;
            end else if (shadow_valid) begin
              state    <= RESTORE;
              idx      <= '0;
              ctx_busy <= 1'b1;
            end else begin
              ctx_err  <= 1'b1;
            end
          end
        end
        SAVE: begin
          sh_q[idx] <= r_q[idx];
          if (idx == IDXW'(NUM_R - 1)) begin
            state        <= IDLE;
            ctx_busy     <= 1'b0;
            ctx_done     <= 1'b1;
            shadow_valid <= 1'b1;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        RESTORE: begin
          r_q[idx] <= sh_q[idx];
          if (idx == IDXW'(NUM_R - 1)) begin
            state    <= IDLE;
            ctx_busy <= 1'b0;
            ctx_done <= 1'b1;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // T registers occupy the low select codes, R follow; unmapped codes read 0
  always_comb begin
    o1 = '0;
    o2 = '0;
    for (int j = 0; j < NUM_T; j++) begin
      if (o1_sel == SELW'(j)) o1 = t_q[j];
      if (o2_sel == SELW'(j)) o2 = t_q[j];
    end
    for (int j = 0; j < NUM_R; j++) begin
      if (o1_sel == SELW'(NUM_T + j)) o1 = r_q[j];
      if (o2_sel == SELW'(NUM_T + j)) o2 = r_q[j];
    end
  end

endmodule

// File: tb/tb_rf_ctx.sv
// Scoreboard bench for rf_ctx: stimulus queues expected values, a negedge monitor
// pops and compares them; a second 3R+4T instance exercises an unmapped select code.
module tb_rf_ctx;

  logic       clk, rst;
  logic [2:0] o1_sel, o2_sel;
  logic [1:0] fun_sel;
  logic [3:0] r_sel, t_sel;
  logic [7:0] i;
  logic       ctx_req, ctx_cmd;
  logic [7:0] o1, o2;
  logic       ctx_busy, ctx_done, ctx_err, shadow_valid;
  logic [7:0] o1_b, o2_b;
  logic       busy_b, done_b, err_b, sv_b;

  rf_ctx #(.WIDTH(8), .NUM_R(4), .NUM_T(4)) dut (
    .clk(clk), .rst(rst), .o1_sel(o1_sel), .o2_sel(o2_sel), .fun_sel(fun_sel),
    .r_sel(r_sel), .t_sel(t_sel), .i(i), .ctx_req(ctx_req), .ctx_cmd(ctx_cmd),
    .o1(o1), .o2(o2), .ctx_busy(ctx_busy), .ctx_done(ctx_done), .ctx_err(ctx_err),
    .shadow_valid(shadow_valid));

  rf_ctx #(.WIDTH(8), .NUM_R(3), .NUM_T(4)) dut_b (
    .clk(clk), .rst(rst), .o1_sel(o1_sel), .o2_sel(o2_sel), .fun_sel(fun_sel),
    .r_sel(r_sel[2:0]), .t_sel(t_sel), .i(i), .ctx_req(ctx_req), .ctx_cmd(ctx_cmd),
    .o1(o1_b), .o2(o2_b), .ctx_busy(busy_b), .ctx_done(done_b), .ctx_err(err_b),
    .shadow_valid(sv_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         sig;
    logic [7:0] exp;
    string      nm;
  } item_t;

  item_t sb[$];
  int    n_chk = 0, n_err = 0;
  int    done_cnt = 0, err_cnt = 0;

  localparam int S_O1 = 0, S_O2 = 1, S_BUSY = 2, S_DONE = 3, S_ERR = 4, S_SV = 5,
                 S_O1B = 6, S_O2B = 7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int sig, input logic [7:0] v, input string nm);
    item_t e;
    e.sig = sig; e.exp = v; e.nm = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ctx_done === 1'b1) done_cnt++;
    if (ctx_err === 1'b1) err_cnt++;
    while (sb.size() > 0) begin
      item_t  e;
      logic [7:0] act;
      e = sb.pop_front();
      case (e.sig)
        S_O1:    act = o1;
        S_O2:    act = o2;
        S_BUSY:  act = {7'd0, ctx_busy};
        S_DONE:  act = {7'd0, ctx_done};
        S_ERR:   act = {7'd0, ctx_err};
        S_SV:    act = {7'd0, shadow_valid};
        S_O1B:   act = o1_b;
        default: act = o2_b;
      endcase
      chk(e.nm, {24'd0, act}, {24'd0, e.exp});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_r(input logic [3:0] rs, input logic [1:0] f, input logic [7:0] d);
    r_sel = rs; fun_sel = f; i = d;
    step();
    r_sel = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; o1_sel = 3'd0; o2_sel = 3'd0; fun_sel = 2'b00; r_sel = 4'b0;
    t_sel = 4'b0; i = 8'h00; ctx_req = 1'b0; ctx_cmd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    o1_sel = 3'd4;
    push(S_O1, 8'h00, "reset_r0"); push(S_BUSY, 0, "reset_busy");
    push(S_SV, 0, "reset_sv"); push(S_DONE, 0, "reset_done"); push(S_ERR, 0, "reset_err");
    step();

    // restore with no saved context
    ctx_req = 1'b1; ctx_cmd = 1'b1;
    step();
    ctx_req = 1'b0;
    push(S_ERR, 1, "err_pulse"); push(S_BUSY, 0, "err_busy");
    step();
    push(S_ERR, 0, "err_one_cycle"); push(S_O1, 8'h00, "err_r0_unchanged");
    step();

    // FunSel ops on R2
    o1_sel = 3'd6;
    op_r(4'b0100, 2'b10, 8'hFF); push(S_O1, 8'hFF, "r2_load");
    op_r(4'b0100, 2'b01, 8'h00); push(S_O1, 8'h00, "r2_inc_wrap");
    op_r(4'b0100, 2'b00, 8'h00); push(S_O1, 8'hFF, "r2_dec_wrap");
    op_r(4'b0100, 2'b11, 8'h00); push(S_O1, 8'h00, "r2_clear");

    // multi-enable load, then T bank load
    op_r(4'b1111, 2'b10, 8'h5A);
    o1_sel = 3'd4; o2_sel = 3'd5;
    push(S_O1, 8'h5A, "multi_r0"); push(S_O2, 8'h5A, "multi_r1");
    t_sel = 4'b1111; fun_sel = 2'b10; i = 8'h3C;
    step();
    t_sel = 4'b0000;
    o1_sel = 3'd7; o2_sel = 3'd6;
    push(S_O1, 8'h5A, "multi_r3"); push(S_O2, 8'h5A, "multi_r2");
    push(S_O1B, 8'h00, "unmapped_sel7"); push(S_O2B, 8'h5A, "b_r2_sel6");
    step();
    o1_sel = 3'd2;
    push(S_O1, 8'h3C, "t2_load");
    step();

    // asynchronous reset mid-cycle
    o1_sel = 3'd4; o2_sel = 3'd2;
    #2 rst = 1'b1;
    #1 push(S_O1, 8'h00, "async_rst_r0"); push(S_O2, 8'h00, "async_rst_t2");
    push(S_BUSY, 0, "async_rst_busy");
    step();
    rst = 1'b0;
    step();

    // save; R0 written in the acceptance cycle is the value copied
    op_r(4'b0010, 2'b10, 8'd2);
    op_r(4'b0100, 2'b10, 8'd3);
    op_r(4'b1000, 2'b10, 8'd4);
    r_sel = 4'b0001; fun_sel = 2'b10; i = 8'd1; ctx_req = 1'b1; ctx_cmd = 1'b0;
    step();
    r_sel = 4'b1111; i = 8'hEE;
    o1_sel = 3'd4;
    push(S_BUSY, 1, "save_busy_c1"); push(S_O1, 8'd1, "save_accept_write");
    for (int m = 2; m <= 4; m++) begin
      step();
      push(S_BUSY, 1, "save_busy"); push(S_DONE, 0, "save_no_early_done");
      push(S_SV, 0, "save_sv_pending");
    end
    step();
    ctx_req = 1'b0; r_sel = 4'b0000;
    o1_sel = 3'd4; o2_sel = 3'd7;
    push(S_BUSY, 0, "save_busy_end"); push(S_DONE, 1, "save_done");
    push(S_SV, 1, "save_sv"); push(S_O1, 8'd1, "save_r0_kept"); push(S_O2, 8'd4, "save_r3_kept");
    step();
    o1_sel = 3'd5; o2_sel = 3'd6;
    push(S_DONE, 0, "save_done_one_cycle");
    push(S_O1, 8'd2, "save_r1_kept"); push(S_O2, 8'd3, "save_r2_kept");
    step();

    // restore with concurrent T1 increment
    op_r(4'b1111, 2'b11, 8'h00);
    o1_sel = 3'd4; o2_sel = 3'd7;
    push(S_O1, 8'h00, "clr_r0"); push(S_O2, 8'h00, "clr_r3");
    ctx_req = 1'b1; ctx_cmd = 1'b1; t_sel = 4'b0010; fun_sel = 2'b01;
    step();
    ctx_req = 1'b0;
    o1_sel = 3'd4; o2_sel = 3'd1;
    push(S_BUSY, 1, "rest_busy"); push(S_O1, 8'h00, "rest_r0_before");
    push(S_O2, 8'd1, "rest_t1_k");
    for (int m = 1; m <= 4; m++) begin
      step();
      o1_sel = 3'(3 + m);
      push(S_O1, 8'(m), "rest_rm"); push(S_O2, 8'(1 + m), "rest_t1_inc");
      push(S_BUSY, (m < 4) ? 8'd1 : 8'd0, "rest_busy_seq");
    end
    push(S_DONE, 1, "rest_done"); push(S_SV, 1, "rest_sv_kept");
    t_sel = 4'b0000;
    step();
    o2_sel = 3'd1;
    push(S_O2, 8'd5, "rest_t1_final"); push(S_DONE, 0, "rest_done_one_cycle");
    step();

    // abort a save with reset
    ctx_req = 1'b1; ctx_cmd = 1'b0;
    step();
    ctx_req = 1'b0;
    push(S_BUSY, 1, "abort_busy");
    step();
    #2 rst = 1'b1;
    #1 push(S_BUSY, 0, "abort_busy_clr"); push(S_SV, 0, "abort_sv_clr");
    push(S_DONE, 0, "abort_no_done");
    step();
    rst = 1'b0;
    step();

    // following save completes normally
    op_r(4'b0001, 2'b10, 8'd7);
    ctx_req = 1'b1; ctx_cmd = 1'b0;
    step();
    ctx_req = 1'b0;
    repeat (3) step();
    step();
    push(S_DONE, 1, "resave_done"); push(S_SV, 1, "resave_sv"); push(S_BUSY, 0, "resave_busy");
    step();
    step();

    begin
      int n = 0;
      while (sb.size() > 0 && n < 10) begin
        step();
        n++;
      end
      if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);
    end
    chk("done_pulse_count", done_cnt, 3);
    chk("err_pulse_count", err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
